// File: rtl/xoodyak_op_sequencer.sv
// Job-level controller for xoodyak_build: walks one AEAD job through
// INIT, NONCE, ASSOC, CRYPT, optional RATCHET and SQUEEZE, with a per-step watchdog.
module xoodyak_op_sequencer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             eph1,
  input  logic             reset_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic             job_decrypt,
  input  logic             job_ratchet,
  input  logic [CNT_W-1:0] job_ad_blocks,
  input  logic [CNT_W-1:0] job_txt_blocks,
  input  logic [127:0]     job_tag,
  output logic             core_start,
  output logic [3:0]       core_opmode,
  input  logic             core_finished,
  input  logic [191:0]     core_textout,
  input  logic             txt_in_valid,
  output logic             txt_in_ready,
  output logic             txt_out_valid,
  output logic [191:0]     txt_out,
  output logic [127:0]     tag_out,
  output logic             job_done,
  output logic             tag_ok,
  output logic             err_timeout
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_INIT    = 3'd1;
  localparam logic [2:0] OP_NONCE   = 3'd2;
  localparam logic [2:0] OP_ASSOC   = 3'd3;
  localparam logic [2:0] OP_ENC     = 3'd4;
  localparam logic [2:0] OP_DEC     = 3'd5;
  localparam logic [2:0] OP_SQUEEZE = 3'd6;
  localparam logic [2:0] OP_RATCHET = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             cont_q, cont_d;
  logic [CNT_W-1:0] ad_q, ad_d;
  logic [CNT_W-1:0] txt_q, txt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             dec_q, rat_q;
  logic             err_q, err_d;
  logic             ok_q, ok_d;
  logic             out_vld_q, out_vld_d;
  logic [191:0]     txt_out_q;
  logic [127:0]     tag_out_q;
  logic [127:0]     tag_q;
  logic             accept, cap_txt, cap_tag, is_crypt;

  function automatic logic [2:0] crypt_op(input logic dec);
    return dec ? OP_DEC : OP_ENC;
  endfunction

  function automatic logic [2:0] tail_op(input logic rat);
    return rat ? OP_RATCHET : OP_SQUEEZE;
  endfunction

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cont_d       = cont_q;
    ad_d         = ad_q;
    txt_d        = txt_q;
    wd_d         = wd_q;
    err_d        = err_q;
    ok_d         = ok_q;
    out_vld_d    = 1'b0;
    accept       = 1'b0;
    cap_txt      = 1'b0;
    cap_tag      = 1'b0;
    is_crypt     = (op_q == OP_ENC) || (op_q == OP_DEC);
    job_ready    = 1'b0;
    core_start   = 1'b0;
    txt_in_ready = 1'b0;
    core_opmode  = 4'h0;
    job_done     = 1'b0;
    tag_ok       = 1'b0;
    err_timeout  = 1'b0;

    case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
          op_d    = OP_INIT;
          cont_d  = 1'b0;
          ad_d    = job_ad_blocks;
          txt_d   = job_txt_blocks;
          err_d   = 1'b0;
          ok_d    = 1'b0;
        end
      end
      S_ISSUE: begin
        core_opmode = {cont_q, op_q};
        wd_d        = '0;
        // A CRYPT step consumes one input block, so it waits for one to exist.
        if (!is_crypt || txt_in_valid) begin
          core_start   = 1'b1;
          txt_in_ready = is_crypt;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        core_opmode = {cont_q, op_q};
        wd_d        = wd_q + WD_W'(1);
        if (core_finished) begin
          state_d = S_ISSUE;
          cont_d  = 1'b0;
          case (op_q)
            OP_INIT:  op_d = OP_NONCE;
            OP_NONCE: op_d = OP_ASSOC;
            OP_ASSOC: begin
              // A count of 0 behaves like 1: one empty-AD absorb.
              if (ad_q > CNT_W'(1)) begin
                ad_d   = ad_q - CNT_W'(1);
                cont_d = 1'b1;
              end else if (txt_q != '0) begin
                op_d = crypt_op(dec_q);
              end else begin
                op_d = tail_op(rat_q);
              end
            end
            OP_ENC, OP_DEC: begin
              out_vld_d = 1'b1;
              cap_txt   = 1'b1;
              if (txt_q > CNT_W'(1)) begin
                txt_d  = txt_q - CNT_W'(1);
                cont_d = 1'b1;
              end else begin
                op_d = tail_op(rat_q);
              end
            end
            OP_RATCHET: op_d = OP_SQUEEZE;
            default: begin
              cap_tag = 1'b1;
              ok_d    = !dec_q || (core_textout[127:0] == tag_q);
              state_d = S_DONE;
            end
          endcase
        end else if (wd_q == WD_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          ok_d    = 1'b0;
        end
      end
      S_DONE: begin
        job_done    = 1'b1;
        tag_ok      = ok_q;
        err_timeout = err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cont_q    <= 1'b0;
      ad_q      <= '0;
      txt_q     <= '0;
      wd_q      <= '0;
      dec_q     <= 1'b0;
      rat_q     <= 1'b0;
      err_q     <= 1'b0;
      ok_q      <= 1'b0;
      out_vld_q <= 1'b0;
      txt_out_q <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cont_q    <= cont_d;
      ad_q      <= ad_d;
      txt_q     <= txt_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      ok_q      <= ok_d;
      out_vld_q <= out_vld_d;
      if (accept) begin
        dec_q <= job_decrypt;
        rat_q <= job_ratchet;
      end
      if (cap_txt) txt_out_q <= core_textout;
      if (cap_tag) tag_out_q <= core_textout[127:0];
    end
  end

  // Expected tag is pure data; it is only read after a job has been accepted.
  always_ff @(posedge eph1) begin
    if (accept) tag_q <= job_tag;
  end

  assign txt_out_valid = out_vld_q;
  assign txt_out       = txt_out_q;
  assign tag_out       = tag_out_q;

endmodule

// File: doc/xoodyak_op_sequencer.md
Name: xoodyak_op_sequencer

Overview:
- Job-level controller in front of xoodyak_build.
- Accepts one AEAD job (encrypt or decrypt, with AD and text block counts) and issues the core opmode sequence: INIT -> NONCE -> ASSOC xN -> CRYPT xM -> [RATCHET] -> SQUEEZE.
- Handshakes each step on the core's finished pulse and streams 192-bit text blocks in and out.
- On decrypt, compares the squeezed tag to the expected tag and reports pass/fail plus a watchdog error.

Parameters:
- CNT_W, 8, width of the AD and text block counters (max 2^CNT_W-1 blocks each).
- TIMEOUT, 64, max cycles from core_start to core_finished before the job aborts with an error.

Ports:
- eph1  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- job_valid  in  1  job request.
- job_ready  out  1  high in IDLE only; a job is accepted when job_valid & job_ready.
- job_decrypt  in  1  0 = encrypt (op 4), 1 = decrypt (op 5); sampled at accept.
- job_ratchet  in  1  insert a RATCHET (op 7) before SQUEEZE; sampled at accept.
- job_ad_blocks  in  CNT_W  AD block count; sampled at accept.
- job_txt_blocks  in  CNT_W  text block count; sampled at accept.
- job_tag  in  128  expected tag for decrypt; sampled at accept.
- core_start  out  1  one-cycle start pulse to xoodyak_build.
- core_opmode  out  4  {continue, op[2:0]}, valid and stable from the start pulse until finished.
- core_finished  in  1  core completion pulse.
- core_textout  in  192  core output; captured on finished.
- txt_in_valid  in  1  next 192-bit input block available upstream.
- txt_in_ready  out  1  one-cycle pulse = block consumed; asserted together with core_start of each CRYPT op.
- txt_out_valid  out  1  one-cycle pulse after each CRYPT finished.
- txt_out  out  192  registered core_textout of the last CRYPT.
- tag_out  out  128  core_textout[127:0] captured at SQUEEZE finished.
- job_done  out  1  one-cycle completion pulse.
- tag_ok  out  1  decrypt: tag_out == job_tag; encrypt: 1. Valid with job_done.
- err_timeout  out  1  set with job_done when the watchdog fired.

Behaviour:
- Reset values: every output is 0, except core_opmode = 4'h0 and job_ready = 1; state = IDLE; counters = 0. Reset is async assert, synchronous deassert at the block boundary.
- States: IDLE, ISSUE, WAIT, DONE. The op register op_q walks INIT(1) -> NONCE(2) -> ASSOC(3) -> CRYPT(4/5) -> RATCHET(7) -> SQUEEZE(6).
- IDLE:
  - On accept, latch all job fields, set op_q = INIT, go to ISSUE.
  - job_ready drops the cycle after accept.
- ISSUE:
  - Drive core_opmode, pulse core_start for one cycle, go to WAIT. The watchdog loads 0.
  - For CRYPT ops, ISSUE stalls (no start) while txt_in_valid = 0. txt_in_ready pulses in the same cycle as core_start.
- WAIT:
  - The watchdog increments each cycle.
  - On core_finished: capture outputs and select the next op, then go to ISSUE, or to DONE after SQUEEZE.
  - A core_finished in ISSUE or IDLE is ignored.
- Continue bit (core_opmode[3]) is 0 for the first ASSOC and first CRYPT op, and 1 for each subsequent one. It is always 0 for INIT, NONCE, RATCHET and SQUEEZE.
- Sequence rules:
  - ASSOC is issued max(job_ad_blocks, 1) times; ad_blocks = 0 still performs one empty-AD absorb.
  - CRYPT is issued job_txt_blocks times; 0 skips straight to RATCHET/SQUEEZE.
  - RATCHET is issued only if job_ratchet = 1.
  - Counters count down, with the transition taken when count reaches 1.
- Latency:
  - Accept to first core_start = 1 cycle.
  - core_finished to next core_start = 1 cycle (ISSUE), plus any txt_in_valid stall.
  - SQUEEZE finished to job_done = 1 cycle (DONE state, then IDLE).
- Watchdog: if the counter reaches TIMEOUT in WAIT:
  - go to DONE with err_timeout = 1 and tag_ok = 0;
  - core_opmode returns to 0;
  - a late core_finished is ignored.
- Counter widths: job_ad_blocks = 2^CNT_W-1 must not wrap. No arithmetic overflow is permitted.
- Mid-job reset: all state clears immediately and no job_done pulse is produced. A job_valid held during reset is accepted on the first cycle after release.

Test Plan:
- Encrypt, ad = 2, txt = 1, no ratchet, core finishes 3 cycles after each start -> core_opmode sequence 1, 2, 3, B, 4, 6. Exactly 6 start pulses; one txt_out_valid; job_done with tag_ok = 1, err_timeout = 0.
- Decrypt, ad = 0, txt = 3, job_tag equal to the modelled squeeze output -> ops 1, 2, 3, 5, D, D, 6; tag_ok = 1. Repeat with job_tag bit 0 flipped -> tag_ok = 0.
- txt_in_valid held low for 10 cycles before the 2nd CRYPT -> no core_start during the stall. txt_in_ready pulses exactly once per block (txt = 2 gives 2 pulses).
- job_ratchet = 1, txt = 0 -> ops 1, 2, 3, 7, 6; no txt_out_valid pulse.
- core_finished never asserted in NONCE, TIMEOUT = 64 -> job_done at 64 cycles into WAIT with err_timeout = 1. Next job accepted normally, and a stray late finished is ignored.
- reset_n pulsed low during the 2nd ASSOC -> all outputs zero, job_ready = 1 after release, no job_done. A fresh job then runs a clean 1, 2, 3... sequence.
